// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file port scheduler:
// read FSM encoding, writeback source identifiers and default widths.
package rf_sched_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned DATA_WIDTH_DEF = 64;
    localparam int unsigned ZERO_REG       = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD1  = 2'd1,
        ST_RD2  = 2'd2,
        ST_RESP = 2'd3
    } rd_state_e;

    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } wr_src_e;

endpackage

// File: rtl/rf_wr_arbiter.sv
// Two-way round-robin arbiter for the register-file write port.
// Muxes the granted source onto the port and suppresses writes to x0.
module rf_wr_arbiter
    import rf_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_wvalid,
    input  logic [ADDR_WIDTH-1:0] exu_waddr,
    input  logic [DATA_WIDTH-1:0] exu_wdata,
    output logic                  exu_wready,
    input  logic                  lsu_wvalid,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  lsu_wready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    wr_src_e last_q, last_d;

    // Grant selection, pointer update and write-port mux
    always_comb begin
        last_d     = last_q;
        exu_wready = 1'b0;
        lsu_wready = 1'b0;
        if (rst) begin
            exu_wready = 1'b0;
            lsu_wready = 1'b0;
        end else if (exu_wvalid && (!lsu_wvalid || (last_q == SRC_LSU))) begin
            exu_wready = 1'b1;
            last_d     = SRC_EXU;
        end else if (lsu_wvalid) begin
            lsu_wready = 1'b1;
            last_d     = SRC_LSU;
        end else begin
            last_d = last_q;
        end
        rf_waddr = lsu_wready ? lsu_waddr : exu_waddr;
        rf_wdata = lsu_wready ? lsu_wdata : exu_wdata;
        // x0 writes are accepted from the source but never reach the RF
        rf_wen   = (exu_wready || lsu_wready) && (rf_waddr != ADDR_WIDTH'(ZERO_REG));
    end

    // Round-robin pointer; reset makes EXU win the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= SRC_LSU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rf_port_sched.sv
// Register-file port scheduler: serialises rs1/rs2 reads onto the single
// read port with same-cycle write forwarding, and hosts the write arbiter.
module rf_port_sched
    import rf_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_rs1,
    input  logic [ADDR_WIDTH-1:0] req_rs2,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_op1,
    output logic [DATA_WIDTH-1:0] resp_op2,
    input  logic                  exu_wvalid,
    output logic                  exu_wready,
    input  logic [ADDR_WIDTH-1:0] exu_waddr,
    input  logic [DATA_WIDTH-1:0] exu_wdata,
    input  logic                  lsu_wvalid,
    output logic                  lsu_wready,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
    logic                  resp_valid_q, resp_valid_d;

    function automatic logic [DATA_WIDTH-1:0] capture_value(
        input logic [ADDR_WIDTH-1:0] idx,
        input logic                  wen,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] rdata
    );
        if (idx == ADDR_WIDTH'(ZERO_REG)) begin
            return {DATA_WIDTH{1'b0}};
        end else if (wen && (waddr == idx)) begin
            return wdata;
        end else begin
            return rdata;
        end
    endfunction

    rf_wr_arbiter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_arbiter (
        .clk        (clk),
        .rst        (rst),
        .exu_wvalid (exu_wvalid),
        .exu_waddr  (exu_waddr),
        .exu_wdata  (exu_wdata),
        .exu_wready (exu_wready),
        .lsu_wvalid (lsu_wvalid),
        .lsu_waddr  (lsu_waddr),
        .lsu_wdata  (lsu_wdata),
        .lsu_wready (lsu_wready),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    // Read FSM next state, read address and operand capture
    always_comb begin
        state_d   = state_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        rf_raddr  = {ADDR_WIDTH{1'b0}};
        req_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = ~rst;
                if (req_valid) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    state_d = ST_RD1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD1: begin
                rf_raddr = rs1_q;
                op1_d    = capture_value(rs1_q, rf_wen, rf_waddr, rf_wdata, rf_rdata);
                if (rs1_q == rs2_q) begin
                    op2_d   = capture_value(rs1_q, rf_wen, rf_waddr, rf_wdata, rf_rdata);
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_RD2;
                end
            end
            ST_RD2: begin
                rf_raddr = rs2_q;
                op2_d    = capture_value(rs2_q, rf_wen, rf_waddr, rf_wdata, rf_rdata);
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        resp_valid_d = (state_d == ST_RESP);
    end

    // FSM, request and operand registers; reset drops any in-flight request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rs1_q        <= {ADDR_WIDTH{1'b0}};
            rs2_q        <= {ADDR_WIDTH{1'b0}};
            op1_q        <= {DATA_WIDTH{1'b0}};
            op2_q        <= {DATA_WIDTH{1'b0}};
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_op1   = op1_q;
    assign resp_op2   = op2_q;

endmodule

// File: doc/rf_port_sched.md
# rf_port_sched

Scheduler between the NPC pipeline and the single-read, single-write register file. It serialises two-operand (rs1/rs2) read requests onto the one read port with valid/ready handshakes. It arbitrates two writeback sources (EXU and LSU) round-robin onto the one write port. It forwards a same-cycle write to the read in flight, so the pipeline never sees a stale operand.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width (32 GPRs)
- DATA_WIDTH, 64, register data width

Ports:
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  operand read request
- req_ready  out  1  request accepted when valid&ready
- req_rs1, req_rs2  in  ADDR_WIDTH  source indices
- resp_valid  out  1  operands available
- resp_ready  in  1  consumer takes operands
- resp_op1, resp_op2  out  DATA_WIDTH  rs1/rs2 values
- exu_wvalid, lsu_wvalid  in  1  writeback requests
- exu_wready, lsu_wready  out  1  grant (combinational from valids and RR pointer)
- exu_waddr, lsu_waddr  in  ADDR_WIDTH  destination index
- exu_wdata, lsu_wdata  in  DATA_WIDTH  writeback data
- rf_raddr  out  ADDR_WIDTH  to RF read address
- rf_rdata  in  DATA_WIDTH  from RF, combinational on rf_raddr
- rf_wen  out  1  to RF write enable
- rf_waddr  out  ADDR_WIDTH  to RF write address
- rf_wdata  out  DATA_WIDTH  to RF write data

## Operation
- Read FSM states: IDLE, RD1, RD2, RESP.
  - IDLE: req_ready=1. On valid&ready, latch rs1/rs2 and go to RD1.
  - RD1: rf_raddr=rs1; capture op1. Go to RESP if rs1==rs2 (op2=op1), else to RD2.
  - RD2: rf_raddr=rs2; capture op2; go to RESP.
  - RESP: resp_valid=1 and op1/op2 held stable. On resp_ready, go to IDLE. No new request is accepted in the same cycle.
  - rf_raddr=0 in IDLE and RESP.
- Captured value per read:
  - 0 if the index is 0.
  - Else rf_wdata if rf_wen && rf_waddr==index (forwarding).
  - Else rf_rdata.
- Write arbiter, one grant per cycle:
  - One valid only: that source is granted.
  - Both valid: the source not granted last is granted. The pointer updates only on a grant.
- Granted write drives rf_waddr/rf_wdata. rf_wen=1 unless waddr==0. An x0 write is still granted (ready=1) but discarded.
- Read FSM and write arbiter are independent. Writes are never stalled by reads.

## Timing
- Request accepted at edge E0. Capture edges: RD1 at E1, RD2 at E2.
  - rs1≠rs2: resp_valid is high from E2 to E3.
  - rs1==rs2: resp_valid is high from E1 to E2.
- Write grant is same-cycle (zero latency). The RF commits at the next posedge.
- Reset (rst high at an edge):
  - State→IDLE; resp_valid=0; op1/op2=0; RR pointer=LSU-last, so EXU wins the first tie.
  - While rst is high: req_ready=0, exu_wready=lsu_wready=0, rf_wen=0.
  - Mid-operation reset drops the in-flight request without a response.
- resp_ready held low in RESP: outputs stay frozen indefinitely, and forwarding has no effect on them.
- Simultaneous write and read to the same index in RD1/RD2: the new value is captured.

## Structure
- Shared package (rf_sched_pkg):
  - FSM state encoding (2-bit: IDLE=0, RD1=1, RD2=2, RESP=3)
  - default ADDR_WIDTH/DATA_WIDTH constants
  - ZERO_REG index constant
- One sub-module, rf_wr_arbiter: 2-way round-robin grant plus write-port mux and x0 suppression. It also feeds rf_wen/waddr/wdata back to the top for forwarding.
- Read FSM and capture registers live in the top.

## Test plan
- Preload x5=0x11, x6=0x22; request rs1=5, rs2=6 → resp_valid 2 cycles after accept; op1=0x11, op2=0x22.
- Request rs1=rs2=7 (x7=0x77) → resp_valid 1 cycle after accept; op1=op2=0x77; rf_raddr never ≠7 during RD.
- EXU writes x6=0xAB in the RD2 cycle of rs1=5, rs2=6 → op2=0xAB; RF holds 0xAB afterwards.
- EXU and LSU both valid for 4 cycles, writing x8, x9 → grants alternate EXU, LSU, EXU, LSU; exactly one rf_wen per cycle.
- LSU writes x0=0xFF → lsu_wready=1, rf_wen=0; later read of rs1=0 returns 0.
- Assert rst during RD2, then hold resp_ready=0 for 5 cycles on the next request:
  - rst during RD2 → next cycle IDLE, resp_valid=0, no response.
  - Next request with resp_ready=0 for 5 cycles → outputs stable; then one handshake → IDLE.
